// File: rtl/lfsr_parity_gen_pkg.sv
// rtl/lfsr_parity_gen_pkg.sv - shared FSM type, next-state helper and maximal tap table
package lfsr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  // Fibonacci step on a zero-extended state; callers truncate to their width.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
    return {state[30:0], ^(state & taps)};
  endfunction

  // Maximal-length feedback masks, bit i = state[i] joins the XOR.
  localparam logic [31:0] MAX_TAPS_2  = 32'h0000_0003;
  localparam logic [31:0] MAX_TAPS_3  = 32'h0000_0006;
  localparam logic [31:0] MAX_TAPS_4  = 32'h0000_000C;
  localparam logic [31:0] MAX_TAPS_5  = 32'h0000_0014;
  localparam logic [31:0] MAX_TAPS_6  = 32'h0000_0030;
  localparam logic [31:0] MAX_TAPS_7  = 32'h0000_0060;
  localparam logic [31:0] MAX_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] MAX_TAPS_9  = 32'h0000_0110;
  localparam logic [31:0] MAX_TAPS_10 = 32'h0000_0240;
  localparam logic [31:0] MAX_TAPS_11 = 32'h0000_0500;
  localparam logic [31:0] MAX_TAPS_12 = 32'h0000_0829;
  localparam logic [31:0] MAX_TAPS_13 = 32'h0000_100D;
  localparam logic [31:0] MAX_TAPS_14 = 32'h0000_2015;
  localparam logic [31:0] MAX_TAPS_15 = 32'h0000_6000;
  localparam logic [31:0] MAX_TAPS_16 = 32'h0000_D008;
  localparam logic [31:0] MAX_TAPS_17 = 32'h0001_2000;
  localparam logic [31:0] MAX_TAPS_18 = 32'h0002_0400;
  localparam logic [31:0] MAX_TAPS_19 = 32'h0004_0023;
  localparam logic [31:0] MAX_TAPS_20 = 32'h0009_0000;
  localparam logic [31:0] MAX_TAPS_21 = 32'h0014_0000;
  localparam logic [31:0] MAX_TAPS_22 = 32'h0030_0000;
  localparam logic [31:0] MAX_TAPS_23 = 32'h0042_0000;
  localparam logic [31:0] MAX_TAPS_24 = 32'h00E1_0000;
  localparam logic [31:0] MAX_TAPS_25 = 32'h0120_0000;
  localparam logic [31:0] MAX_TAPS_26 = 32'h0200_0023;
  localparam logic [31:0] MAX_TAPS_27 = 32'h0400_0013;
  localparam logic [31:0] MAX_TAPS_28 = 32'h0900_0000;
  localparam logic [31:0] MAX_TAPS_29 = 32'h1400_0000;
  localparam logic [31:0] MAX_TAPS_30 = 32'h2000_0029;
  localparam logic [31:0] MAX_TAPS_31 = 32'h4800_0000;
  localparam logic [31:0] MAX_TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_parity_gen_if.sv
// rtl/lfsr_parity_gen_if.sv - valid/ready word stream carrying {parity, state}
interface lfsr_parity_gen_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH:0] out_data;
  logic           out_valid;
  logic           out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_parity_gen_core.sv
// rtl/lfsr_parity_gen_core.sv - LFSR state register with seed load and zero-seed guard
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS = 7'b1100000,
  parameter logic [WIDTH-1:0] SEED = 7'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] next_state;

  assign next_state = WIDTH'(lfsr_next(32'(state), 32'(TAPS)));

  // An all-zero state would lock the register, so zero loads fall back to SEED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/lfsr_parity_gen.sv
// rtl/lfsr_parity_gen.sv - LFSR word source with parity, back-pressure and period measurement
module lfsr_parity_gen
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS = 7'b1100000,
  parameter logic [WIDTH-1:0] SEED = 7'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             parity_odd,
  lfsr_parity_gen_if.master stream,
  output logic             seed_nack,
  output logic             period_wrap,
  output logic [WIDTH-1:0] period_len
);

  fsm_e             fsm_q;
  fsm_e             fsm_d;
  logic [WIDTH-1:0] lfsr_state;
  logic [WIDTH-1:0] lfsr_next_state;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_inc;
  logic             mode_q;
  logic             core_load;
  logic             core_step;
  logic             nack_d;
  logic             handshake;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (seed),
    .step     (core_step),
    .state    (lfsr_state)
  );

  assign stream.out_valid = (fsm_q == RUN);
  assign stream.out_data  = {(^lfsr_state) ^ mode_q, lfsr_state};
  assign handshake        = stream.out_valid && stream.out_ready;

  assign lfsr_next_state  = WIDTH'(lfsr_next(32'(lfsr_state), 32'(TAPS)));
  assign seed_eff         = (seed == '0) ? SEED : seed;
  assign cnt_inc          = (cnt_q == {WIDTH{1'b1}}) ? cnt_q : cnt_q + WIDTH'(1);

  always_comb begin
    fsm_d     = fsm_q;
    core_load = 1'b0;
    core_step = 1'b0;
    nack_d    = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        core_load = seed_load;
        if (ena) fsm_d = RUN;
      end
      RUN: begin
        nack_d = seed_load;
        // Valid is never withdrawn; leaving RUN waits for the pending word to be taken.
        if (handshake) begin
          core_step = 1'b1;
          if (!ena) fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      seed_q      <= SEED;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      period_len  <= '0;
      period_wrap <= 1'b0;
      seed_nack   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      seed_nack   <= nack_d;
      period_wrap <= 1'b0;
      if (core_load) begin
        seed_q <= seed_eff;
        mode_q <= parity_odd;
        cnt_q  <= '0;
      end else if (handshake) begin
        if (lfsr_next_state == seed_q) begin
          period_wrap <= 1'b1;
          period_len  <= cnt_inc;
          cnt_q       <= '0;
        end else begin
          cnt_q <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_parity_gen.sv
// tb/tb_lfsr_parity_gen.sv - directed scoreboard bench for lfsr_parity_gen
module tb_lfsr_parity_gen;
  import lfsr_pkg::*;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       seed_load;
  logic [6:0] seed;
  logic       parity_odd;
  logic       seed_nack;
  logic       period_wrap;
  logic [6:0] period_len;

  lfsr_parity_gen_if #(.WIDTH(7)) bus ();

  lfsr_parity_gen #(
    .WIDTH (7),
    .TAPS  (7'b1100000),
    .SEED  (7'h01)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .seed_load   (seed_load),
    .seed        (seed),
    .parity_odd  (parity_odd),
    .stream      (bus),
    .seed_nack   (seed_nack),
    .period_wrap (period_wrap),
    .period_len  (period_len)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [6:0] m_state;
  logic       m_mode;
  logic [7:0] tbl [8];
  int         nwrap;
  int         first_wrap;
  int         second_wrap;
  logic [6:0] len_at_wrap;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] m_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  function automatic logic [7:0] m_word(input logic [6:0] s, input logic m);
    return {(^s) ^ m, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_adv();
    exp_q.push_back(m_word(m_state, m_mode));
    m_state = m_next(m_state);
  endtask

  // Compares the word about to be accepted, then advances one clock.
  task automatic cycle();
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow observed=0x%0h expected=none", bus.out_data);
      end else begin
        check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tbl = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'h41, 8'h03};
    rst = 1'b1; ena = 1'b0; seed_load = 1'b0; seed = '0; parity_odd = 1'b0;
    bus.out_ready = 1'b0;
    m_state = 7'h01; m_mode = 1'b0;
    @(negedge clk);
    cycle();
    rst = 1'b0;
    cycle();

    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data", 32'(bus.out_data), 32'h81);
    check("rst_nack", 32'(seed_nack), 0);
    check("rst_wrap", 32'(period_wrap), 0);
    check("rst_len", 32'(period_len), 0);
    check("rst_fsm", 32'(u_dut.fsm_q), 32'(IDLE));

    ena = 1'b1; bus.out_ready = 1'b1;
    check("valid_before_ena", 32'(bus.out_valid), 0);
    cycle();
    check("valid_after_ena", 32'(bus.out_valid), 1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tbl[i]);
      m_state = m_next(m_state);
      cycle();
    end

    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_data", 32'(bus.out_data), 32'(m_word(m_state, m_mode)));
      check("hold_valid", 32'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_adv();
      cycle();
    end

    ena = 1'b0;
    push_adv();
    cycle();
    check("idle_valid", 32'(bus.out_valid), 0);

    seed_load = 1'b1; seed = 7'h01; parity_odd = 1'b0; ena = 1'b1;
    cycle();
    seed_load = 1'b0;
    m_state = 7'h01; m_mode = 1'b0;
    check("reload_word", 32'(bus.out_data), 32'h81);
    check("reload_valid", 32'(bus.out_valid), 1);

    nwrap = 0; first_wrap = 0; second_wrap = 0; len_at_wrap = '0;
    for (int i = 1; i <= 260; i++) begin
      push_adv();
      cycle();
      if (period_wrap) begin
        nwrap++;
        if (nwrap == 1) begin
          first_wrap = i;
          len_at_wrap = period_len;
        end else if (nwrap == 2) begin
          second_wrap = i;
        end
      end
    end
    check("first_wrap_at", 32'(first_wrap), 127);
    check("second_wrap_at", 32'(second_wrap), 254);
    check("wrap_count", 32'(nwrap), 2);
    check("period_len", 32'(len_at_wrap), 127);

    ena = 1'b0;
    push_adv();
    cycle();
    seed_load = 1'b1; seed = 7'h00; parity_odd = 1'b1;
    cycle();
    seed_load = 1'b0;
    m_state = 7'h01; m_mode = 1'b1;
    check("zero_seed_word", 32'(bus.out_data), 32'h01);
    check("zero_seed_valid", 32'(bus.out_valid), 0);
    ena = 1'b1;
    cycle();
    check("odd_run_valid", 32'(bus.out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      push_adv();
      cycle();
    end

    seed_load = 1'b1; seed = 7'h55; parity_odd = 1'b0;
    push_adv();
    cycle();
    seed_load = 1'b0;
    check("nack_pulse", 32'(seed_nack), 1);
    push_adv();
    cycle();
    check("nack_clear", 32'(seed_nack), 0);
    push_adv();
    cycle();

    rst = 1'b1;
    cycle();
    check("midrst_valid", 32'(bus.out_valid), 0);
    check("midrst_fsm", 32'(u_dut.fsm_q), 32'(IDLE));
    check("midrst_len", 32'(period_len), 0);
    check("midrst_data", 32'(bus.out_data), 32'h81);
    rst = 1'b0; ena = 1'b0;
    cycle();
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
